// File: rtl/ps2_defs_pkg.sv
// rtl/ps2_defs_pkg.sv - shared FSM encodings and PS/2 scan-code constants
package ps2_defs;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_POP    = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DECODE = 2'd3
   } ps2_state_t;

   localparam logic [7:0] PS2_EXT     = 8'hE0;
   localparam logic [7:0] PS2_BRK     = 8'hF0;
   localparam logic [7:0] PS2_BRK_ALT = 8'h00;
   localparam logic [7:0] PS2_SHIFT_L = 8'h12;
   localparam logic [7:0] PS2_SHIFT_R = 8'h59;

endpackage

// File: rtl/ps2_kbd_ctrl_scan2ascii.sv
// rtl/ps2_kbd_ctrl_scan2ascii.sv - combinational set-2 scan code to ASCII ROM
module ps2_scan2ascii (
   input  logic [7:0] code,
   input  logic       shift,
   input  logic       ext,
   output logic [7:0] ascii
);

   logic [7:0] letter;

   always_comb begin
      letter = 8'h00;
      case (code)
         8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;  8'h21: letter = 8'h63;
         8'h23: letter = 8'h64;  8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
         8'h34: letter = 8'h67;  8'h33: letter = 8'h68;  8'h43: letter = 8'h69;
         8'h3B: letter = 8'h6A;  8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
         8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;  8'h44: letter = 8'h6F;
         8'h4D: letter = 8'h70;  8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
         8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;  8'h3C: letter = 8'h75;
         8'h2A: letter = 8'h76;  8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
         8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
         default: letter = 8'h00;
      endcase
   end

   always_comb begin
      ascii = 8'h00;
      if (!ext) begin
         if (letter != 8'h00) begin
            ascii = shift ? (letter - 8'h20) : letter;
         end else begin
            case (code)
               8'h16: ascii = shift ? 8'h21 : 8'h31;
               8'h1E: ascii = shift ? 8'h40 : 8'h32;
               8'h26: ascii = shift ? 8'h23 : 8'h33;
               8'h25: ascii = shift ? 8'h24 : 8'h34;
               8'h2E: ascii = shift ? 8'h25 : 8'h35;
               8'h36: ascii = shift ? 8'h5E : 8'h36;
               8'h3D: ascii = shift ? 8'h26 : 8'h37;
               8'h3E: ascii = shift ? 8'h2A : 8'h38;
               8'h46: ascii = shift ? 8'h28 : 8'h39;
               8'h45: ascii = shift ? 8'h29 : 8'h30;
               8'h29: ascii = 8'h20;
               default: ascii = 8'h00;
            endcase
         end
      end
   end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// rtl/ps2_kbd_ctrl.sv - PS/2 FIFO consumer: prefix sequencing, key state, key events
// Optional typematic repeat events: define PS2_CTRL_TYPEMATIC_EN.
module ps2_kbd_ctrl
   import ps2_defs::*;
#(
   parameter int         CNT_W   = 8,
   parameter logic [7:0] SHIFT_L = PS2_SHIFT_L,
   parameter logic [7:0] SHIFT_R = PS2_SHIFT_R
) (
   input  logic             i_clk,
   input  logic             i_clr,
   input  logic [7:0]       i_ps2_data,
   input  logic             i_ps2_ready,
   input  logic             i_ps2_overflow,
   output logic             o_nextdata_n,
   output logic [7:0]       o_key_code,
   output logic [7:0]       o_key_ascii,
   output logic             o_key_ext,
   output logic             o_key_valid,
   output logic             o_key_pressed,
   output logic             o_shift,
   output logic [CNT_W-1:0] o_press_count,
   output logic             o_overflow
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   ps2_state_t       state, state_n;
   logic [7:0]       code_r, code_n;
   logic             brk, brk_n, ext, ext_n;
   logic             nd_n, valid_n, pressed_n, shift_n, key_ext_n;
   logic [7:0]       key_code_n, key_ascii_n, map_ascii;
   logic [CNT_W-1:0] count_n;
   logic             is_shift;

   ps2_scan2ascii u_map (
      .code  (code_r),
      .shift (o_shift),
      .ext   (ext),
      .ascii (map_ascii)
   );

   assign is_shift = (code_r == SHIFT_L) || (code_r == SHIFT_R);

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         state         <= ST_IDLE;
         code_r        <= 8'h00;
         brk           <= 1'b0;
         ext           <= 1'b0;
         o_nextdata_n  <= 1'b1;
         o_key_code    <= 8'h00;
         o_key_ascii   <= 8'h00;
         o_key_ext     <= 1'b0;
         o_key_valid   <= 1'b0;
         o_key_pressed <= 1'b0;
         o_shift       <= 1'b0;
         o_press_count <= '0;
         o_overflow    <= 1'b0;
      end else begin
         state         <= state_n;
         code_r        <= code_n;
         brk           <= brk_n;
         ext           <= ext_n;
         o_nextdata_n  <= nd_n;
         o_key_code    <= key_code_n;
         o_key_ascii   <= key_ascii_n;
         o_key_ext     <= key_ext_n;
         o_key_valid   <= valid_n;
         o_key_pressed <= pressed_n;
         o_shift       <= shift_n;
         o_press_count <= count_n;
         o_overflow    <= o_overflow | i_ps2_overflow;
      end
   end

   always_comb begin
      state_n     = state;
      code_n      = code_r;
      brk_n       = brk;
      ext_n       = ext;
      valid_n     = 1'b0;
      key_code_n  = o_key_code;
      key_ascii_n = o_key_ascii;
      key_ext_n   = o_key_ext;
      pressed_n   = o_key_pressed;
      shift_n     = o_shift;
      count_n     = o_press_count;
      case (state)
         ST_IDLE: begin
            if (i_ps2_ready) begin
               code_n  = i_ps2_data;
               state_n = ST_POP;
            end
         end
         ST_POP:  state_n = ST_WAIT;
         ST_WAIT: state_n = ST_DECODE;
         ST_DECODE: begin
            state_n = ST_IDLE;
            if (code_r == PS2_EXT) begin
               ext_n = 1'b1;
            end else if (code_r == PS2_BRK || code_r == PS2_BRK_ALT) begin
               brk_n = 1'b1;
            end else if (brk) begin
               if (is_shift)
                  shift_n = 1'b0;
               else if (code_r == o_key_code)
                  pressed_n = 1'b0;
               brk_n = 1'b0;
               ext_n = 1'b0;
            end else if (is_shift) begin
               shift_n = 1'b1;
               ext_n   = 1'b0;
            end else if (o_key_pressed && code_r == o_key_code) begin
               ext_n = 1'b0;
`ifdef PS2_CTRL_TYPEMATIC_EN
               valid_n     = 1'b1;
               key_ascii_n = map_ascii;
`endif
            end else begin
               key_code_n  = code_r;
               key_ext_n   = ext;
               key_ascii_n = map_ascii;
               pressed_n   = 1'b1;
               count_n     = o_press_count + CNT_ONE;
               valid_n     = 1'b1;
               ext_n       = 1'b0;
            end
         end
         default: state_n = ST_IDLE;
      endcase
      // Pop strobe is registered, so it is low exactly while the FSM sits in POP.
      nd_n = (state_n != ST_POP);
   end

endmodule
